uart_tx_sched: RTL and testbench

Two-requester UART transmit scheduler with parity. Arbitrates round-robin between two byte producers and serialises the granted byte onto a single `tx` line as start / 8 data (LSB first) / parity / stop. Every bit boundary is paced by the `tx_en` tick from the baud generator, so the block owns the shared serial line and the baud-tick resource between the producers and the pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_arb2.sv | 21 ++
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
//   tx_state_e : frame sequencing states
//   DATA_W     : data bits per frame
//   PAR_EVEN / PAR_ODD : parity mode selectors for the PARITY_ODD parameter
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: combinational two-way round-robin pick.
//   valid_i[1:0]  : requester valids (bit N = requester N)
//   last_grant_i  : requester granted most recently
//   gnt_o[1:0]    : one-hot pick, all zero when nothing is valid
module uart_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // On contention the requester that did not win last time gets the byte.
  always_comb begin
    gnt_o = '0;
    if (valid_i[0] && (!valid_i[1] || last_grant_i)) begin
      gnt_o[0] = 1'b1;
    end else if (valid_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester UART transmitter with round-robin arbitration.
// Frame: start(0) / 8 data bits LSB first / parity / STOP_BITS stop bits(1).
// Every bit boundary advances only on a tx_en baud tick.
//   clk, rst_n              : clock, asynchronous active-low reset
//   tx_en                   : one-clk baud tick
//   reqN_valid / reqN_data  : requester N offers a byte
//   reqN_ready              : byte from requester N accepted this cycle
//   tx                      : registered serial line, idle high
//   busy                    : frame pending or in flight
//   grant_id                : requester owning the current/most recent frame
module uart_tx_sched #(
  parameter int unsigned DATA_W     = uart_pkg::DATA_W,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx,
  output logic              busy,
  output logic              grant_id
);

  import uart_pkg::*;

  localparam logic PAR_INV   = (PARITY_ODD == PAR_ODD);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [1:0]        gnt;
  logic              idle_ok;
  logic              accept;
  logic              parity_bit;

  uart_rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  // rst_n gates ready so nothing is handshaken while reset is held.
  assign idle_ok    = (state_q == ST_IDLE) && rst_n;
  assign accept     = idle_ok && (gnt != 2'b00);
  assign parity_bit = (^data_q) ^ PAR_INV;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)                      state_d = ST_PEND;
      ST_PEND:  if (tx_en)                       state_d = ST_START;
      ST_START: if (tx_en)                       state_d = ST_DATA;
      ST_DATA:  if (tx_en && cnt_q == 3'd7)      state_d = ST_PAR;
      ST_PAR:   if (tx_en)                       state_d = ST_STOP;
      ST_STOP:  if (tx_en && stop_q == STOP_LAST) state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    tx_d       = tx_q;
    grant_d    = grant_q;
    last_d     = last_q;
    req0_ready = idle_ok && gnt[0];
    req1_ready = idle_ok && gnt[1];
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = gnt[1] ? req1_data : req0_data;
          grant_d = gnt[1];
          last_d  = gnt[1];
        end
      end
      ST_PEND: if (tx_en) tx_d = 1'b0;
      ST_START: begin
        if (tx_en) begin
          tx_d  = data_q[0];
          cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tx_en) begin
          tx_d  = (cnt_q == 3'd7) ? parity_bit : data_q[cnt_q + 3'd1];
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_PAR: begin
        if (tx_en) begin
          tx_d   = 1'b1;
          stop_d = 1'b0;
        end
      end
      ST_STOP: if (tx_en && stop_q != STOP_LAST) stop_d = stop_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign tx       = tx_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched.
// Three instances: even/1-stop and odd/1-stop share all stimulus, the
// even/2-stop instance shares clock, reset and tx_en but has its own requesters.
module tb_uart_tx_sched;

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       r0_rdy, r1_rdy, tx, busy, gid;
  logic       o_r0_rdy, o_r1_rdy, o_tx, o_busy, o_gid;
  logic       s_v0, s_v1;
  logic [7:0] s_d0, s_d1;
  logic       s_r0, s_r1, s_tx, s_busy, s_gid;

  int unsigned vectors;
  int unsigned miscompares;

  uart_tx_sched #(.DATA_W(8), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy),
    .tx(tx), .busy(busy), .grant_id(gid)
  );

  uart_tx_sched #(.DATA_W(8), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(o_r0_rdy),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(o_r1_rdy),
    .tx(o_tx), .busy(o_busy), .grant_id(o_gid)
  );

  uart_tx_sched #(.DATA_W(8), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .req0_valid(s_v0), .req0_data(s_d0), .req0_ready(s_r0),
    .req1_valid(s_v1), .req1_data(s_d1), .req1_ready(s_r1),
    .tx(s_tx), .busy(s_busy), .grant_id(s_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge in PEND with tx_en held high; returns at the
  // negedge where the stop bit is on the line.
  task automatic frame_fast(input string tag, input logic [7:0] d,
                            input logic pe, input logic po, input logic g);
    logic [10:0] exp_e, exp_o;
    exp_e = {1'b1, pe, d, 1'b0};
    exp_o = {1'b1, po, d, 1'b0};
    chk({tag, "_pend_tx"}, tx, 1);
    chk({tag, "_pend_busy"}, busy, 1);
    chk({tag, "_pend_obusy"}, o_busy, 1);
    chk({tag, "_gid"}, gid, g);
    chk({tag, "_ogid"}, o_gid, g);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk({tag, "_bit_even"}, tx, exp_e[i]);
      chk({tag, "_bit_odd"}, o_tx, exp_o[i]);
      chk({tag, "_busy"}, busy, 1);
    end
  endtask

  initial begin
    logic [10:0] exp11;
    logic [11:0] exp12;
    int unsigned glitch, low, fcnt, hicnt;
    logic        seen;

    vectors = 0; miscompares = 0;
    rst_n = 1'b0; tx_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    s_v0 = 1'b0; s_v1 = 1'b0; s_d0 = '0; s_d1 = '0;

    // Reset values, valid present but reset held
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hA5; #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_rdy0", r0_rdy, 0);
    chk("rst_rdy1", r1_rdy, 0);
    chk("rst_s_tx", s_tx, 1);

    // A5, tx_en continuously high (including the accept cycle)
    @(negedge clk); rst_n = 1'b1; tx_en = 1'b1; #1;
    chk("a5_rdy0", r0_rdy, 1);
    chk("a5_rdy1", r1_rdy, 0);
    chk("a5_ordy0", o_r0_rdy, 1);
    @(negedge clk); req0_data = 8'hFF; #1;
    chk("a5_pend_rdy0", r0_rdy, 0);
    frame_fast("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    chk("a5_stop_rdy0", r0_rdy, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("a5_idle_busy", busy, 0);
    chk("a5_idle_tx", tx, 1);

    // 07: even parity 1, odd parity 0
    req0_valid = 1'b1; req0_data = 8'h07; #1;
    chk("p07_rdy0", r0_rdy, 1);
    @(negedge clk); req0_valid = 1'b0;
    frame_fast("p07", 8'h07, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("p07_idle_busy", busy, 0);

    // Both valid from reset: 11, 22, 11, 22
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22; #1;
    chk("alt0_rdy0", r0_rdy, 1);
    chk("alt0_rdy1", r1_rdy, 0);
    @(negedge clk);
    frame_fast("alt0", 8'h11, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("alt1_rdy1", r1_rdy, 1);
    chk("alt1_rdy0", r0_rdy, 0);
    chk("alt1_ordy1", o_r1_rdy, 1);
    @(negedge clk);
    frame_fast("alt1", 8'h22, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("alt2_rdy0", r0_rdy, 1);
    @(negedge clk);
    frame_fast("alt2", 8'h11, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("alt3_rdy1", r1_rdy, 1);
    @(negedge clk);
    frame_fast("alt3", 8'h22, 1'b0, 1'b1, 1'b1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("alt_idle_busy", busy, 0);

    // C3 with a tick every 435 clks
    tx_en = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hC3; #1;
    chk("slow_rdy0", r0_rdy, 1);
    @(negedge clk); req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("slow_pend_tx", tx, 1);
    chk("slow_pend_busy", busy, 1);
    exp11 = {1'b1, 1'b0, 8'hC3, 1'b0};
    glitch = 0; low = 0; fcnt = 0;
    for (int i = 0; i < 11; i++) begin
      tx_en = 1'b1;
      @(negedge clk);
      tx_en = 1'b0;
      chk("slow_bit", tx, exp11[i]);
      if (busy === 1'b1) fcnt++;
      if (i == 0 && tx === 1'b0) low++;
      for (int j = 0; j < 434; j++) begin
        @(negedge clk);
        if (busy === 1'b1) fcnt++;
        if (tx !== exp11[i]) glitch++;
        if (i == 0 && tx === 1'b0) low++;
      end
    end
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    chk("slow_glitch", glitch, 0);
    chk("slow_start_len", low, 435);
    chk("slow_frame_len", fcnt, 4785);
    chk("slow_end_busy", busy, 0);
    chk("slow_end_tx", tx, 1);

    // Reset during data bit 4, then req1 = 3C
    tx_en = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00; #1;
    chk("rmid_rdy0", r0_rdy, 1);
    @(negedge clk); req0_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rmid_bit4_tx", tx, 0);
    chk("rmid_bit4_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("rmid_tx", tx, 1);
    chk("rmid_busy", busy, 0);
    chk("rmid_rdy0", r0_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h3C; #1;
    chk("r3c_rdy1", r1_rdy, 1);
    chk("r3c_rdy0", r0_rdy, 0);
    @(negedge clk); req1_valid = 1'b0;
    frame_fast("r3c", 8'h3C, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("r3c_idle_busy", busy, 0);

    // Two stop bits, back-to-back 81 bytes
    s_v0 = 1'b1; s_d0 = 8'h81; #1;
    chk("s2_rdy0", s_r0, 1);
    chk("s2_rdy1", s_r1, 0);
    @(negedge clk);
    chk("s2_pend_tx", s_tx, 1);
    chk("s2_pend_busy", s_busy, 1);
    exp12 = {2'b11, 1'b0, 8'h81, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("s2_bit", s_tx, exp12[i]);
    end
    hicnt = 2; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (s_tx === 1'b1) hicnt++;
      else seen = 1'b1;
    end
    chk("s2_gap", hicnt, 4);
    chk("s2_next_start", s_tx, 0);
    chk("s2_gid", s_gid, 0);
    s_v0 = 1'b0;
    repeat (12) @(negedge clk);
    chk("s2_end_busy", s_busy, 0);
    chk("s2_end_tx", s_tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
